// File: rtl/me_pe_sequencer.sv
// Control and address sequencer for a linear chain of N SAD processing
// elements doing full-search motion estimation over N horizontal
// displacements. Addresses lead the per-PE controls by one cycle so the
// controls line up with data returned by a 1-cycle synchronous-read memory.
module me_pe_sequencer #(
  parameter int N = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(N*N)-1:0]          ref_addr,
  output logic [$clog2(N*(2*N-1))-1:0]    s1_addr,
  output logic [$clog2(N*(2*N-1))-1:0]    s2_addr,
  output logic [N-1:0]                    s1s2mux,
  output logic [N-1:0]                    newDist,
  output logic [N-1:0]                    sad_valid
);

  localparam int unsigned NU   = N;
  localparam int unsigned NN   = NU * NU;
  localparam int unsigned L    = NN + NU - 1;      // number of address steps
  localparam int unsigned LAST = NN + NU;          // cycle carrying done
  localparam int unsigned W    = 2 * NU - 1;       // search window row length
  localparam int unsigned CW   = $clog2(LAST + 1);
  localparam int unsigned RAW  = $clog2(NN);
  localparam int unsigned SAW  = $clog2(NU * W);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // RUN spans cycles 0..LAST (one past the last step) so the delayed
  // controls, the trailing sad_valid pulses and done are all driven from
  // a single cycle counter; busy is simply "RUN and counter <= L".
  logic [0:0]    state, nxt_state;
  logic [CW-1:0] cnt;

  int unsigned   cyc, nxt_cyc, s;
  logic          run_n;
  logic          busy_n, done_n;
  logic [RAW-1:0] ref_n;
  logic [SAW-1:0] s1_n, s2_n;
  logic [N-1:0]  mux_n, nd_n, sv_n;

  // Next state/cycle, and the registered output values for that next cycle.
  always_comb begin
    cyc       = {{(32-CW){1'b0}}, cnt};
    nxt_state = IDLE;
    nxt_cyc   = 0;
    if ((state == IDLE || cyc == LAST) && start) begin
      nxt_state = RUN;
      nxt_cyc   = 0;
    end else if (state == RUN && cyc < LAST) begin
      nxt_state = RUN;
      nxt_cyc   = cyc + 1;
    end

    run_n  = (nxt_state == RUN);
    busy_n = run_n && (nxt_cyc <= L);
    done_n = run_n && (nxt_cyc == LAST);

    ref_n = '0;
    s1_n  = '0;
    s2_n  = '0;
    if (run_n && nxt_cyc < NN) begin
      ref_n = RAW'(nxt_cyc);
      s1_n  = SAW'((nxt_cyc / NU) * W + (nxt_cyc % NU));
    end
    if (run_n && nxt_cyc >= NU && nxt_cyc < L)
      s2_n = SAW'((nxt_cyc / NU - 1) * W + NU + (nxt_cyc % NU));

    // Controls in cycle c belong to step c-1.
    mux_n = '1;
    nd_n  = '1;
    s     = 0;
    if (run_n && nxt_cyc >= 1 && nxt_cyc <= L) begin
      s = nxt_cyc - 1;
      for (int unsigned k = 0; k < NU; k++) begin
        mux_n[k] = ((s % NU) >= k);
        nd_n[k]  = (s == k);
      end
    end

    sv_n = '0;
    for (int unsigned k = 0; k < NU; k++)
      sv_n[k] = run_n && (nxt_cyc == NN + 1 + k);
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ref_addr  <= '0;
      s1_addr   <= '0;
      s2_addr   <= '0;
      s1s2mux   <= '1;
      newDist   <= '1;
      sad_valid <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= CW'(nxt_cyc);
      busy      <= busy_n;
      done      <= done_n;
      ref_addr  <= ref_n;
      s1_addr   <= s1_n;
      s2_addr   <= s2_n;
      s1s2mux   <= mux_n;
      newDist   <= nd_n;
      sad_valid <= sv_n;
    end
  end

endmodule

// File: tb/tb_me_pe_sequencer.sv
// Bench for me_pe_sequencer: a cycle-number reference model, a 4-PE SAD
// chain fed by 1-cycle memories, directed literal checks and random traffic.
module tb_me_pe_sequencer;

  localparam int N    = 4;
  localparam int NN   = N * N;
  localparam int L    = NN + N - 1;
  localparam int LAST = NN + N;
  localparam int W    = 2 * N - 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] ref_addr;
  logic [4:0] s1_addr, s2_addr;
  logic [3:0] s1s2mux, newDist, sad_valid;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int mn       = -1;   // model: cycle number within the current run, -1 idle

  logic [7:0] rmem [NN];
  logic [7:0] smem [N*W];
  logic [7:0] ref_q, s1_q, s2_q;
  logic [7:0] rpipe [N];
  logic [7:0] rin [N];
  int         acc [N];

  me_pe_sequencer #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done),
    .ref_addr(ref_addr), .s1_addr(s1_addr), .s2_addr(s2_addr),
    .s1s2mux(s1s2mux), .newDist(newDist), .sad_valid(sad_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  function automatic int sad(input int k);
    int sum = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sum += absdiff(rmem[i*N+j], smem[i*W+j+k]);
    return sum;
  endfunction

  // Run tracking from the handshake rules: accept start only when not busy.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mn <= -1;
    else if (!(mn >= 0 && mn <= L) && start) mn <= 0;
    else if (mn >= 0 && mn < LAST) mn <= mn + 1;
    else mn <= -1;
  end

  // Synchronous-read memories and the PE chain driven by the DUT controls.
  always_comb begin
    rin[0] = ref_q;
    for (int k = 1; k < N; k++) rin[k] = rpipe[k-1];
  end

  always @(posedge clock) begin
    ref_q <= rmem[ref_addr];
    s1_q  <= smem[s1_addr];
    s2_q  <= smem[s2_addr];
    for (int k = 0; k < N; k++) begin
      acc[k]   <= (newDist[k] ? 0 : acc[k]) + absdiff(rin[k], s1s2mux[k] ? s1_q : s2_q);
      rpipe[k] <= rin[k];
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      int eref, es1, es2, emux, end_, esv, st;
      eref = 0; es1 = 0; es2 = 0; emux = 15; end_ = 15; esv = 0;
      if (mn >= 0 && mn < NN) begin
        eref = mn;
        es1  = (mn / N) * W + mn % N;
      end
      if (mn >= N && mn < L) es2 = (mn / N - 1) * W + N + mn % N;
      if (mn >= 1 && mn <= L) begin
        st = mn - 1; emux = 0; end_ = 0;
        for (int k = 0; k < N; k++) begin
          if (st % N >= k) emux |= (1 << k);
          if (st == k)     end_ |= (1 << k);
        end
      end
      if (mn > NN && mn <= NN + N) esv = 1 << (mn - NN - 1);
      chk("busy", int'(busy), int'(mn >= 0 && mn <= L));
      chk("done", int'(done), int'(mn == LAST));
      chk("ref_addr", int'(ref_addr), eref);
      chk("s1_addr", int'(s1_addr), es1);
      chk("s2_addr", int'(s2_addr), es2);
      chk("s1s2mux", int'(s1s2mux), emux);
      chk("newDist", int'(newDist), end_);
      chk("sad_valid", int'(sad_valid), esv);
      for (int k = 0; k < N; k++)
        if (esv == (1 << k)) chk($sformatf("pe%0d_sad", k), acc[k], sad(k));
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sv"}, int'(sad_valid), 0);
    chk({tag, "_addr"}, int'(ref_addr) + int'(s1_addr) + int'(s2_addr), 0);
    chk({tag, "_mux"}, int'(s1s2mux), 15);
    chk({tag, "_nd"}, int'(newDist), 15);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) rmem[i*N+j] = 8'(i*N + j + 1);
      for (int c = 0; c < W; c++)
        smem[i*W+c] = (c >= 2 && c < 2 + N) ? 8'(i*N + (c-2) + 1) : 8'd200;
    end

    // Reset held with start high; start dropped together with release.
    #1 reset_n = 1'b0;
    start = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    next_cycle();
    reset_n = 1'b1;
    start = 1'b0;
    repeat (3) next_cycle();
    chk("idle_after_release", int'(busy), 0);

    // Directed run: E0 is the next edge.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int n = 0; n <= 21; n++) begin
      if (n == 6)  start = 1'b1;   // ignored: busy
      if (n == 7)  start = 1'b0;
      if (n == 19) start = 1'b1;   // held through the done cycle
      if (n == 21) start = 1'b0;
      @(negedge clock);
      case (n)
        0:  begin chk("c0_ref", int'(ref_addr), 0); chk("c0_s1", int'(s1_addr), 0);
                  chk("c0_s2", int'(s2_addr), 0); chk("c0_busy", int'(busy), 1); end
        3:  chk("c3_newDist", int'(newDist), 4);
        5:  begin chk("c5_ref", int'(ref_addr), 5); chk("c5_s1", int'(s1_addr), 8);
                  chk("c5_s2", int'(s2_addr), 5); end
        8:  begin chk("c8_newDist", int'(newDist), 0); chk("c8_mux", int'(s1s2mux), 15); end
        17: begin chk("c17_ref", int'(ref_addr), 0); chk("c17_s1", int'(s1_addr), 0);
                  chk("c17_s2", int'(s2_addr), 26); chk("c17_sv", int'(sad_valid), 1);
                  chk("pe0_nonzero", int'(acc[0] != 0), 1); end
        18: begin chk("c18_sv", int'(sad_valid), 2); chk("pe1_nonzero", int'(acc[1] != 0), 1); end
        19: begin chk("c19_sv", int'(sad_valid), 4); chk("pe2_sad", acc[2], 0);
                  chk("c19_busy", int'(busy), 1); end
        20: begin chk("c20_done", int'(done), 1); chk("c20_busy", int'(busy), 0);
                  chk("c20_sv", int'(sad_valid), 8); chk("pe3_nonzero", int'(acc[3] != 0), 1); end
        21: begin chk("c21_busy", int'(busy), 1); chk("c21_ref", int'(ref_addr), 0);
                  chk("c21_s1", int'(s1_addr), 0); chk("c21_s2", int'(s2_addr), 0); end
        default: ;
      endcase
      next_cycle();
    end

    // Back-to-back run is now in cycle 1; abort it in cycle 10.
    repeat (9) next_cycle();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrun");
    next_cycle();
    reset_n = 1'b1;

    // Random traffic; memories refreshed only between runs.
    for (int c = 0; c < 2000; c++) begin
      if (mn == -1 && ($urandom % 4) == 0)
        for (int a = 0; a < N*W; a++) begin
          smem[a] = 8'($urandom);
          if (a < NN) rmem[a] = 8'($urandom);
        end
      start   = (($urandom % 3) == 0);
      reset_n = (($urandom % 80) != 0);
      next_cycle();
    end
    reset_n = 1'b1;
    start = 1'b0;
    repeat (LAST + 3) next_cycle();
    chk("final_idle", int'(busy), 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
